// File: rtl/axi4_read_data_buffer.sv
// axi4_read_data_buffer: AXI4-Lite R-channel receiver with read credits,
// a first-word-fall-through beat FIFO and sticky/saturating error tracking.
module axi4_read_data_buffer #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 ACLK,
    input  logic                                 ARESETN,
    input  logic                                 STARTRD,
    input  logic [DATA_WIDTH-1:0]                RDATA,
    input  logic [1:0]                           RRESP,
    input  logic                                 RVALID,
    output logic                                 RREADY,
    output logic                                 r_VALID,
    output logic [DATA_WIDTH-1:0]                r_DATA_out,
    output logic [1:0]                           rresp_out,
    input  logic                                 r_POP,
    output logic                                 r_DONE,
    output logic                                 r_IDLE,
    output logic                                 r_CREDIT_FULL,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] r_PENDING,
    output logic [$clog2(DEPTH+1)-1:0]           r_COUNT,
    output logic                                 r_ERR,
    output logic [7:0]                           r_ERR_CNT,
    input  logic                                 r_ERR_CLR
);
    localparam int PW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH+1:0] mem_q [DEPTH];
    logic [PW-1:0]         pend_q, pend_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         wptr_q, rptr_q;
    logic                  done_q, err_q, err_d;
    logic [7:0]            ecnt_q, ecnt_d;
    logic                  acc, pop, start_ok, bad;

    // RREADY depends on registered state only, never on RVALID
    assign RREADY   = (pend_q != '0) && (cnt_q != CW'(DEPTH));
    assign acc      = RVALID && RREADY;
    assign r_VALID  = cnt_q != '0;
    assign pop      = r_POP && r_VALID;
    assign start_ok = STARTRD && (pend_q != PW'(MAX_OUTSTANDING));
    assign bad      = acc && RRESP[1];

    always_comb begin
        pend_d = pend_q + PW'(start_ok) - PW'(acc);
        cnt_d  = cnt_q + CW'(acc) - CW'(pop);
        err_d  = bad || (err_q && !r_ERR_CLR);
        ecnt_d = bad ? (r_ERR_CLR ? 8'd1 : ecnt_q + 8'(ecnt_q != 8'hff))
                     : (r_ERR_CLR ? 8'd0 : ecnt_q);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pend_q <= '0;
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ecnt_q <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            wptr_q <= wptr_q + AW'(acc);
            rptr_q <= rptr_q + AW'(pop);
            done_q <= acc;
            err_q  <= err_d;
            ecnt_q <= ecnt_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (acc) mem_q[wptr_q] <= {RRESP, RDATA};
    end

    assign {rresp_out, r_DATA_out} = r_VALID ? mem_q[rptr_q] : '0;
    assign r_DONE        = done_q;
    assign r_IDLE        = (pend_q == '0) && (cnt_q == '0);
    assign r_CREDIT_FULL = pend_q == PW'(MAX_OUTSTANDING);
    assign r_PENDING     = pend_q;
    assign r_COUNT       = cnt_q;
    assign r_ERR         = err_q;
    assign r_ERR_CNT     = ecnt_q;
endmodule

// File: tb/tb_axi4_read_data_buffer.sv
// tb_axi4_read_data_buffer: directed stimulus with a queue-based reference model
// compared on every falling edge, plus literal checkpoints.
module tb_axi4_read_data_buffer;
    localparam int DEPTH = 4;
    localparam int MAXO  = 8;

    logic        clk = 0, rst_n = 0;
    logic        STARTRD = 0, RVALID = 0, r_POP = 0, r_ERR_CLR = 0;
    logic [31:0] RDATA = 0;
    logic [1:0]  RRESP = 0;
    logic        RREADY, r_VALID, r_DONE, r_IDLE, r_CREDIT_FULL, r_ERR;
    logic [31:0] r_DATA_out;
    logic [1:0]  rresp_out;
    logic [3:0]  r_PENDING;
    logic [2:0]  r_COUNT;
    logic [7:0]  r_ERR_CNT;

    axi4_read_data_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .ACLK(clk), .ARESETN(rst_n), .STARTRD(STARTRD), .RDATA(RDATA), .RRESP(RRESP),
        .RVALID(RVALID), .RREADY(RREADY), .r_VALID(r_VALID), .r_DATA_out(r_DATA_out),
        .rresp_out(rresp_out), .r_POP(r_POP), .r_DONE(r_DONE), .r_IDLE(r_IDLE),
        .r_CREDIT_FULL(r_CREDIT_FULL), .r_PENDING(r_PENDING), .r_COUNT(r_COUNT),
        .r_ERR(r_ERR), .r_ERR_CNT(r_ERR_CNT), .r_ERR_CLR(r_ERR_CLR)
    );

    always #5 clk = ~clk;

    int pass_n = 0, total_n = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total_n++;
        if (a === e) pass_n++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    endtask

    task automatic timeout(input string n);
        total_n++;
        $display("FAIL %s: wait bound expired at %0t", n, $time);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // reference model: a queue of {resp,data} beats and plain integer counters
    logic [33:0] mq[$];
    int          mpend = 0, mecnt = 0;
    logic        mdone = 0, merr = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mpend = 0; mdone = 0; merr = 0; mecnt = 0;
        end else begin
            bit rdy, a, s;
            rdy = (mpend != 0) && (mq.size() != DEPTH);
            a = RVALID && rdy;
            s = STARTRD && (mpend != MAXO);
            if (r_POP && mq.size() != 0) void'(mq.pop_front());
            if (a) mq.push_back({RRESP, RDATA});
            mpend = mpend + int'(s) - int'(a);
            mdone = a;
            if (a && RRESP[1]) begin
                merr = 1;
                mecnt = r_ERR_CLR ? 1 : (mecnt < 255 ? mecnt + 1 : 255);
            end else if (r_ERR_CLR) begin
                merr = 0;
                mecnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [33:0] h;
        h = '0;
        if (mq.size() != 0) h = mq[0];
        chk("m_rready", RREADY, (mpend != 0) && (mq.size() != DEPTH));
        chk("m_valid", r_VALID, mq.size() != 0);
        chk("m_data", r_DATA_out, h[31:0]);
        chk("m_resp", rresp_out, h[33:32]);
        chk("m_done", r_DONE, mdone);
        chk("m_idle", r_IDLE, (mpend == 0) && (mq.size() == 0));
        chk("m_full", r_CREDIT_FULL, mpend == MAXO);
        chk("m_pend", r_PENDING, mpend);
        chk("m_count", r_COUNT, mq.size());
        chk("m_err", r_ERR, merr);
        chk("m_ecnt", r_ERR_CNT, mecnt);
    end

    task automatic beat(input logic [1:0] rr, input logic [31:0] d);
        RVALID = 1; RRESP = rr; RDATA = d;
        for (int i = 0; i < 16 && !RREADY; i++) step;
        if (!RREADY) timeout("beat_ready");
        step;
        RVALID = 0; RRESP = 0;
    endtask

    task automatic drain(input string n);
        for (int i = 0; i < 64 && !r_IDLE; i++) begin
            RVALID = r_PENDING != 0;
            RDATA = $urandom;
            r_POP = r_VALID;
            step;
        end
        RVALID = 0; r_POP = 0;
        if (!r_IDLE) timeout(n);
    endtask

    logic a;
    int   v, got, starts, accs, pops, dones;

    initial begin
        repeat (3) step;
        rst_n = 1;
        chk("rst_idle", r_IDLE, 1);
        chk("rst_rready", RREADY, 0);
        chk("rst_valid", r_VALID, 0);

        STARTRD = 1; step; STARTRD = 0;
        chk("single_rready", RREADY, 1);
        RVALID = 1; RDATA = 32'hDEADBEEF; RRESP = 0; step; RVALID = 0;
        chk("single_done", r_DONE, 1);
        chk("single_valid", r_VALID, 1);
        chk("single_data", r_DATA_out, 32'hDEADBEEF);
        chk("single_resp", rresp_out, 0);
        step;
        chk("single_done_once", r_DONE, 0);
        r_POP = 1; step; r_POP = 0;
        chk("single_idle", r_IDLE, 1);
        chk("single_zero", r_DATA_out, 0);

        repeat (6) begin STARTRD = 1; step; end
        STARTRD = 0;
        v = 1; RVALID = 1;
        repeat (8) begin RDATA = v; a = RREADY; step; if (a) v++; end
        chk("b2b_rready", RREADY, 0);
        chk("b2b_count", r_COUNT, 4);
        chk("b2b_pend", r_PENDING, 2);
        got = 0;
        for (int i = 0; i < 40 && got < 6; i++) begin
            RVALID = v <= 6;
            RDATA = v;
            r_POP = r_VALID && (i % 2 == 0);
            if (r_POP) begin chk("b2b_order", r_DATA_out, got + 1); got++; end
            a = RVALID && RREADY;
            step;
            if (a) v++;
        end
        RVALID = 0; r_POP = 0;
        if (got < 6) timeout("b2b_drain");
        chk("b2b_idle", r_IDLE, 1);

        repeat (9) begin STARTRD = 1; step; end
        STARTRD = 0;
        chk("cred_pend", r_PENDING, 8);
        chk("cred_full", r_CREDIT_FULL, 1);
        STARTRD = 1; RVALID = 1; RDATA = 32'h55; step; STARTRD = 0; RVALID = 0;
        chk("cred_pend7", r_PENDING, 7);
        chk("cred_notfull", r_CREDIT_FULL, 0);
        drain("cred_drain");

        r_POP = 1;
        repeat (3) begin STARTRD = 1; step; end
        STARTRD = 0;
        beat(2'b10, 1); beat(2'b11, 2); beat(2'b00, 3);
        chk("err_flag", r_ERR, 1);
        chk("err_cnt2", r_ERR_CNT, 2);
        STARTRD = 1; step; STARTRD = 0;
        r_ERR_CLR = 1; beat(2'b10, 4); r_ERR_CLR = 0;
        chk("err_clr_flag", r_ERR, 1);
        chk("err_clr_cnt1", r_ERR_CNT, 1);
        starts = 0; accs = 0;
        for (int i = 0; i < 400 && accs < 300; i++) begin
            STARTRD = starts < 300;
            if (STARTRD) starts++;
            RVALID = 1; RRESP = 2'b11;
            a = RREADY;
            step;
            if (a) accs++;
        end
        STARTRD = 0; RVALID = 0; RRESP = 0;
        if (accs < 300) timeout("err_sat_stream");
        chk("err_sat", r_ERR_CNT, 255);
        r_ERR_CLR = 1; step; r_ERR_CLR = 0; r_POP = 0;
        chk("err_clear_flag", r_ERR, 0);
        chk("err_clear_cnt", r_ERR_CNT, 0);

        r_POP = 1; starts = 0; accs = 0; pops = 0; dones = 0;
        for (int i = 0; i < 100 && pops < 20; i++) begin
            STARTRD = starts < 20;
            if (STARTRD) starts++;
            RVALID = accs < 20;
            RDATA = 100 + accs;
            a = RVALID && RREADY;
            if (r_VALID) begin chk("wrap_order", r_DATA_out, 100 + pops); pops++; end
            step;
            if (a) accs++;
            dones += int'(r_DONE);
            chk("wrap_level", r_COUNT <= 1, 1);
        end
        STARTRD = 0; RVALID = 0; r_POP = 0;
        if (pops < 20) timeout("wrap_stream");
        chk("wrap_dones", dones, 20);
        chk("wrap_idle", r_IDLE, 1);

        repeat (5) begin STARTRD = 1; step; end
        STARTRD = 0;
        accs = 0; RVALID = 1;
        for (int i = 0; i < 10 && accs < 3; i++) begin
            RDATA = 200 + accs; a = RREADY; step; if (a) accs++;
        end
        RVALID = 0;
        chk("mid_count", r_COUNT, 3);
        chk("mid_pend", r_PENDING, 2);
        #2 rst_n = 0;
        #1;
        chk("ar_rready", RREADY, 0);
        chk("ar_valid", r_VALID, 0);
        chk("ar_data", r_DATA_out, 0);
        chk("ar_resp", rresp_out, 0);
        chk("ar_done", r_DONE, 0);
        chk("ar_idle", r_IDLE, 1);
        chk("ar_full", r_CREDIT_FULL, 0);
        chk("ar_pend", r_PENDING, 0);
        chk("ar_count", r_COUNT, 0);
        chk("ar_err", r_ERR, 0);
        chk("ar_ecnt", r_ERR_CNT, 0);
        @(posedge clk);
        #1 rst_n = 1;
        STARTRD = 1; step; STARTRD = 0;
        chk("post_rready", RREADY, 1);
        RVALID = 1; RDATA = 32'hCAFEF00D; step; RVALID = 0;
        chk("post_data", r_DATA_out, 32'hCAFEF00D);
        chk("post_count", r_COUNT, 1);
        r_POP = 1; step; r_POP = 0;
        chk("post_idle", r_IDLE, 1);
        step;
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/axi4_read_data_buffer.md
# axi4_read_data_buffer

Master-side AXI4-Lite read data (R) channel receiver supporting multiple outstanding reads and buffering of returned beats. Each issued read address is credited via `STARTRD`; the block asserts `RREADY` only while reads are outstanding and buffer space exists. Accepted data and responses are queued in a first-word-fall-through FIFO that master logic drains with a valid/pop interface. Error responses are flagged and counted. The block sits between the AXI4-Lite R channel and the master's consumer logic, next to the read address channel that pulses `STARTRD`.

## Interface
- `DATA_WIDTH`, 32, RDATA / FIFO data width.
- `DEPTH`, 4, FIFO entries; power of 2, ≥ 2.
- `MAX_OUTSTANDING`, 8, maximum credited-but-unreturned reads; ≥ 1.
- `ACLK` in 1: clock; all logic on the rising edge.
- `ARESETN` in 1: asynchronous, active-low reset.
- `STARTRD` in 1: one-cycle pulse per issued read address; adds one credit.
- `RDATA` in DATA_WIDTH: read data from the subordinate.
- `RRESP` in 2: read response from the subordinate.
- `RVALID` in 1: read valid from the subordinate.
- `RREADY` out 1: ready to the subordinate.
- `r_VALID` out 1: FIFO head holds a beat.
- `r_DATA_out` out DATA_WIDTH: FIFO head data; 0 when empty.
- `rresp_out` out 2: FIFO head response; 0 when empty.
- `r_POP` in 1: consume the head beat; ignored when `r_VALID` = 0.
- `r_DONE` out 1: one-cycle pulse, one cycle after each accepted beat.
- `r_IDLE` out 1: no reads outstanding and FIFO empty.
- `r_CREDIT_FULL` out 1: pending count equals MAX_OUTSTANDING.
- `r_PENDING` out clog2(MAX_OUTSTANDING+1): outstanding read count.
- `r_COUNT` out clog2(DEPTH+1): FIFO occupancy.
- `r_ERR` out 1: sticky; set by a SLVERR/DECERR beat.
- `r_ERR_CNT` out 8: saturating count of error beats (max 255).
- `r_ERR_CLR` in 1: clears `r_ERR` and `r_ERR_CNT`.

## Operation
- Reset values: `RREADY` 0, `r_VALID` 0, `r_DATA_out` 0, `rresp_out` 0, `r_DONE` 0, `r_IDLE` 1, `r_CREDIT_FULL` 0, `r_PENDING` 0, `r_COUNT` 0, `r_ERR` 0, `r_ERR_CNT` 0. FIFO pointers are 0. Contents need no reset.
- `RREADY` = (pending ≠ 0) && (count ≠ DEPTH). It is decoded from registers only, with no combinational path from any input.
- Accept = `RVALID` && `RREADY`. On accept, {RRESP, RDATA} is written at the write pointer.
- Credit accept: `start_ok` = `STARTRD` && (pending ≠ MAX_OUTSTANDING).
  - A `STARTRD` at full credit is dropped, even if an accept occurs in the same cycle.
  - The master must not pulse `STARTRD` while `r_CREDIT_FULL` = 1.
- Pending update: pending_next = pending + start_ok − accept. Simultaneous start and accept leave the count unchanged.
- FIFO:
  - Write on accept; read on `r_POP` && `r_VALID`.
  - Simultaneous write and read leaves the count unchanged and is legal at any non-empty level.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Head outputs are combinational from storage at the read pointer, gated to 0 when empty.
- Errors:
  - An accepted beat with `RRESP[1]` = 1 (SLVERR 2'b10 or DECERR 2'b11) sets `r_ERR` and increments `r_ERR_CNT`. The counter saturates at 255.
  - `r_ERR_CLR` alone clears both.
  - When `r_ERR_CLR` and an error accept coincide, the result is `r_ERR` = 1 and `r_ERR_CNT` = 1.
- A beat with `RVALID` high and pending = 0 is not accepted, since `RREADY` is 0. This is a protocol violation upstream and is not counted.
- `r_IDLE` = (pending = 0) && (count = 0). `r_CREDIT_FULL` is decoded from registers.

## Timing
- `STARTRD` sampled at edge N with empty credit: `RREADY` is 1 in the cycle after edge N, provided the FIFO is not full.
- Beat accepted at edge N:
  - `r_VALID`, `r_COUNT`, `r_DATA_out` and `rresp_out` update after edge N (latency 1 to the head).
  - `r_DONE` is high for exactly the cycle after edge N.
- Pop at edge N: the next entry, or zeros, appears after edge N.
- FIFO full: `RREADY` drops the cycle after the filling accept. It returns the cycle after a pop.
- Sustained throughput is one beat per cycle when credits are available and the consumer pops every cycle.
- `ARESETN` low mid-operation:
  - All outputs go to reset values immediately (asynchronously).
  - Pending credits and queued beats are discarded.
  - Operation resumes on the first rising `ACLK` edge after deassertion.

## Test plan
- Single read: reset, one `STARTRD` pulse, then RVALID with RDATA=32'hDEADBEEF, RRESP=00 → `RREADY` high one cycle after the pulse; `r_DONE` pulses once; `r_VALID`=1 with head DEADBEEF/00. `r_POP` → `r_IDLE`=1, `r_DATA_out`=0.
- Back-to-back, DEPTH=4: 6 `STARTRD` pulses; subordinate returns values 1–6 with RVALID held high and no pops → 4 beats accepted, `RREADY`=0 with `r_COUNT`=4 and `r_PENDING`=2. Popping one at a time → beats 5 and 6 are accepted after the pops, output order 1–6 with no loss or duplication.
- Credit limit, MAX_OUTSTANDING=8: 9 `STARTRD` pulses with no data → `r_PENDING`=8, `r_CREDIT_FULL`=1, ninth pulse dropped. `STARTRD` coincident with an accept at full credit → `r_PENDING` becomes 7.
- Errors: beats with RRESP 10, 11, 00 → `r_ERR`=1, `r_ERR_CNT`=2. `r_ERR_CLR` coincident with an error accept → `r_ERR`=1, `r_ERR_CNT`=1. 300 error beats → `r_ERR_CNT` saturates at 255.
- Wrap and simultaneous push/pop: 20 reads with the consumer popping every cycle → FIFO level stays ≤ 1, data order preserved across pointer wrap, `r_DONE` count = 20.
- Reset mid-transfer: assert `ARESETN` low with `r_COUNT`=3 and `r_PENDING`=2 → all outputs are at reset values within the same cycle. After release, a single read completes correctly.
